// File: rtl/call_dispatcher.sv
// call_dispatcher: queues calls in a small FIFO and runs them one at a time
// against one-hot callee channels, returning results or error responses.
module call_dispatcher #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_ch,
    input  logic [DATA_W-1:0]        cmd_arg,
    input  logic                     cmd_has_out,
    output logic [NUM_CH-1:0]        ch_req,
    output logic [DATA_W-1:0]        ch_arg,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*DATA_W-1:0] ch_res,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_ch,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [15:0]              call_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [4:0] NCH = 5'(NUM_CH);

    typedef struct packed {
        logic [3:0]        ch;
        logic [DATA_W-1:0] arg;
        logic              has_out;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, CALL, RESP} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          rdy_en;
    logic          full, empty, push, pop;
    logic          head_ok, ack_hit;
    logic [DATA_W-1:0] res_sel;

    state_t            state_q, state_d;
    logic [3:0]        cur_ch_q, cur_ch_d;
    logic              has_out_q, has_out_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [NUM_CH-1:0] ch_req_d;
    logic [DATA_W-1:0] ch_arg_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [3:0]        rsp_ch_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic [15:0]       cnt_d;

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    // rdy_en keeps cmd_ready low while in reset and until the first edge after
    assign cmd_ready = rdy_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign head_ok   = {1'b0, head.ch} < NCH;
    assign ack_hit   = |(ch_ack & ch_req);
    assign busy      = !empty || (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_ch, cmd_arg, cmd_has_out};
    end

    always_comb begin
        res_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_req[i]) res_sel = ch_res[i*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        has_out_d   = has_out_q;
        wait_d      = wait_q;
        ch_req_d    = ch_req;
        ch_arg_d    = ch_arg;
        rsp_valid_d = rsp_valid;
        rsp_ch_d    = rsp_ch;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        cnt_d       = call_cnt;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cur_ch_d  = head.ch;
                    has_out_d = head.has_out;
                    if (head_ok) begin
                        state_d  = CALL;
                        ch_req_d = NUM_CH'(1) << head.ch;
                        ch_arg_d = head.arg;
                        wait_d   = '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_ch_d    = head.ch;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            CALL: begin
                // an ack in the last allowed cycle still completes normally
                if (ack_hit) begin
                    ch_req_d = '0;
                    if (call_cnt != 16'hFFFF) cnt_d = call_cnt + 16'd1;
                    if (has_out_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_ch_d    = cur_ch_q;
                        rsp_data_d  = res_sel;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    ch_req_d    = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ch_d    = cur_ch_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_ch_q  <= '0;
            has_out_q <= 1'b0;
            wait_q    <= '0;
            ch_req    <= '0;
            ch_arg    <= '0;
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            call_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            has_out_q <= has_out_d;
            wait_q    <= wait_d;
            ch_req    <= ch_req_d;
            ch_arg    <= ch_arg_d;
            rsp_valid <= rsp_valid_d;
            rsp_ch    <= rsp_ch_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            call_cnt  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_call_dispatcher.sv
// tb_call_dispatcher: table vectors, directed corner sequences and a
// randomized run checked against a transaction-level call model.
module tb_call_dispatcher;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_ch = '0;
    logic [7:0]  cmd_arg = '0;
    logic        cmd_has_out = 1'b0;
    logic [3:0]  ch_req;
    logic [7:0]  ch_arg;
    logic [3:0]  ch_ack = '0;
    logic [31:0] ch_res = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_ch;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] call_cnt;

    always #5 clk = ~clk;

    call_dispatcher #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_arg(cmd_arg), .cmd_has_out(cmd_has_out),
        .ch_req(ch_req), .ch_arg(ch_arg), .ch_ack(ch_ack), .ch_res(ch_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .call_cnt(call_cnt)
    );

    typedef struct {
        logic [3:0] ch;
        logic [7:0] arg;
        logic       has_out;
        int         d;
        logic [7:0] res;
    } cmd_t;

    typedef struct {
        logic [3:0] ch;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        logic [3:0] ch;
        logic [7:0] arg;
        logic       has_out;
        int         d;
        logic [7:0] res;
        int         len;
        int         lat;
        bit         rsp;
        logic [3:0] rch;
        logic [7:0] rdata;
        logic       rerr;
        int         cnt;
    } vec_t;

    cmd_t cmd_q[$];
    cmd_t callee_q[$];
    rsp_t exp_q[$];
    cmd_t cur;
    rsp_t last_rsp;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_total = 0;
    int model_cnt = 0;
    int req_n = 0;
    int last_len = 0;
    int last_lat = -1;
    int rsp_seen = 0;
    int rdy_pct = 100;
    int send_pct = 100;
    bit req_active = 1'b0;
    bit rsp_hold = 1'b0;
    logic [12:0] held = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, want, cyc);
        end
    endtask

    // Call model: outcome of each accepted call follows from its channel,
    // the callee's ack delay and has_out alone.
    task automatic accept(cmd_t c);
        acc_total++;
        acc_cyc = cyc;
        if (c.ch >= NUM_CH) begin
            exp_q.push_back('{c.ch, 8'h00, 1'b1});
        end else begin
            callee_q.push_back(c);
            if (c.d <= TIMEOUT) begin
                if (model_cnt < 65535) model_cnt++;
                if (c.has_out) exp_q.push_back('{c.ch, c.res, 1'b0});
            end else begin
                exp_q.push_back('{c.ch, 8'h00, 1'b1});
            end
        end
    endtask

    task automatic step();
        rsp_t e;
        @(negedge clk);
        cyc++;
        ch_ack = '0;
        ch_res = $urandom();
        if (ch_req != '0) begin
            if (!req_active) begin
                req_active = 1'b1;
                req_n = 1;
                last_lat = cyc - acc_cyc;
                if (callee_q.size() == 0) begin
                    chk("req_unexpected", 32'(ch_req), 32'h0);
                    cur = '{4'h0, 8'h00, 1'b0, 1000, 8'h00};
                end else begin
                    cur = callee_q.pop_front();
                end
            end else begin
                req_n++;
            end
            chk("req_onehot", 32'(ch_req), 32'(4'b0001 << cur.ch));
            chk("req_arg", 32'(ch_arg), 32'(cur.arg));
            if (req_n == cur.d) begin
                ch_ack[cur.ch] = 1'b1;
                ch_res[cur.ch*8 +: 8] = cur.res;
            end
        end else if (req_active) begin
            req_active = 1'b0;
            last_len = req_n;
            chk("req_len", req_n, (cur.d < TIMEOUT) ? cur.d : TIMEOUT);
        end
        for (int j = 0; j < NUM_CH; j++)
            if (!ch_req[j] && $urandom_range(0, 7) == 0) ch_ack[j] = 1'b1;

        if (rsp_valid) begin
            if (rsp_hold) chk("rsp_stable", 32'({rsp_ch, rsp_data, rsp_err}), 32'(held));
            held = {rsp_ch, rsp_data, rsp_err};
        end else if (rsp_hold) begin
            chk("rsp_dropped", 32'(rsp_valid), 32'h1);
        end
        rsp_ready = ($urandom_range(0, 99) < rdy_pct);
        rsp_hold = rsp_valid && !rsp_ready;
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            last_rsp = '{rsp_ch, rsp_data, rsp_err};
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", 32'({rsp_ch, rsp_data, rsp_err}), 32'({e.ch, e.data, e.err}));
            end
        end

        if (cmd_q.size() != 0 && $urandom_range(0, 99) < send_pct) begin
            cmd_valid   = 1'b1;
            cmd_ch      = cmd_q[0].ch;
            cmd_arg     = cmd_q[0].arg;
            cmd_has_out = cmd_q[0].has_out;
            if (cmd_ready) begin
                accept(cmd_q[0]);
                void'(cmd_q.pop_front());
            end
        end else begin
            cmd_valid   = 1'b0;
            cmd_ch      = 4'($urandom());
            cmd_arg     = 8'($urandom());
            cmd_has_out = 1'($urandom());
        end
    endtask

    task automatic drain(int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || cmd_valid || req_active || cmd_q.size() != 0 ||
                    exp_q.size() != 0) && n < limit);
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_exp_left", exp_q.size(), 0);
        chk("drain_cmd_left", cmd_q.size(), 0);
    endtask

    task automatic run_vec(vec_t v);
        int n;
        int base;
        cmd_t c;
        c = '{v.ch, v.arg, v.has_out, v.d, v.res};
        cmd_q.push_back(c);
        last_len = 0;
        last_lat = -1;
        base = rsp_seen;
        n = 0;
        while (cmd_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 200);
        chk("vec_busy_end", 32'(busy), 32'h0);
        chk("vec_req_len", last_len, v.len);
        chk("vec_latency", last_lat, v.lat);
        chk("vec_rsp_count", rsp_seen - base, 32'(v.rsp));
        if (v.rsp)
            chk("vec_rsp", 32'({last_rsp.ch, last_rsp.data, last_rsp.err}),
                32'({v.rch, v.rdata, v.rerr}));
        chk("vec_call_cnt", 32'(call_cnt), v.cnt);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];
    cmd_t c;
    int   n;
    int   base;
    int   r;

    initial begin
        tbl[0] = '{4'd2,  8'h01, 1'b1, 3,  8'h01, 3,  2,  1'b1, 4'd2,  8'h01, 1'b0, 1};
        tbl[1] = '{4'd1,  8'h05, 1'b0, 2,  8'h77, 2,  2,  1'b0, 4'd0,  8'h00, 1'b0, 2};
        tbl[2] = '{4'd3,  8'h33, 1'b1, 99, 8'h00, 15, 2,  1'b1, 4'd3,  8'h00, 1'b1, 2};
        tbl[3] = '{4'd3,  8'h44, 1'b1, 15, 8'hA5, 15, 2,  1'b1, 4'd3,  8'hA5, 1'b0, 3};
        tbl[4] = '{4'd7,  8'h12, 1'b1, 0,  8'h00, 0,  -1, 1'b1, 4'd7,  8'h00, 1'b1, 3};
        tbl[5] = '{4'd0,  8'h9C, 1'b0, 99, 8'h00, 15, 2,  1'b1, 4'd0,  8'h00, 1'b1, 3};
        tbl[6] = '{4'd1,  8'hE1, 1'b1, 1,  8'h5A, 1,  2,  1'b1, 4'd1,  8'h5A, 1'b0, 4};
        tbl[7] = '{4'd15, 8'h00, 1'b0, 0,  8'h00, 0,  -1, 1'b1, 4'd15, 8'h00, 1'b1, 4};
        tbl[8] = '{4'd2,  8'hFF, 1'b1, 14, 8'hC3, 14, 2,  1'b1, 4'd2,  8'hC3, 1'b0, 5};
        tbl[9] = '{4'd0,  8'h3C, 1'b1, 16, 8'h11, 15, 2,  1'b1, 4'd0,  8'h00, 1'b1, 5};

        step();
        step();
        chk("rst_outputs",
            32'({cmd_ready, ch_req, ch_arg, rsp_valid, rsp_ch, rsp_data, rsp_err, busy}),
            32'h0);
        chk("rst_call_cnt", 32'(call_cnt), 32'h0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // invalid channel response must hold while the caller stalls
        rdy_pct = 0;
        cmd_q.push_back('{4'd7, 8'h5A, 1'b1, 0, 8'h00});
        n = 0;
        do begin
            step();
            n++;
        end while (!rsp_valid && n < 20);
        chk("inv_rsp_valid", 32'(rsp_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("inv_hold", 32'({rsp_valid, rsp_ch, rsp_data, rsp_err, ch_req}),
                32'({1'b1, 4'd7, 8'h00, 1'b1, 4'h0}));
        end
        rdy_pct = 100;
        drain(50);

        // fill the FIFO behind a stalled call
        cmd_q.push_back('{4'd0, 8'h10, 1'b1, 99, 8'h00});
        n = 0;
        do begin
            step();
            n++;
        end while (ch_req == '0 && n < 20);
        chk("bp_first_req", 32'(ch_req), 32'h1);
        cmd_q.push_back('{4'd1, 8'h21, 1'b1, 99, 8'h00});
        cmd_q.push_back('{4'd2, 8'h22, 1'b0, 99, 8'h00});
        cmd_q.push_back('{4'd3, 8'h23, 1'b1, 99, 8'h00});
        cmd_q.push_back('{4'd0, 8'h24, 1'b0, 99, 8'h00});
        cmd_q.push_back('{4'd1, 8'h25, 1'b1, 99, 8'h00});
        base = acc_total;
        n = 0;
        do begin
            step();
            n++;
        end while (cmd_ready && n < 20);
        chk("bp_accepts_at_full", acc_total - base, DEPTH);
        step();
        chk("bp_ready_low", 32'(cmd_ready), 32'h0);
        drain(400);
        chk("bp_call_cnt", 32'(call_cnt), 32'(model_cnt));

        // reset in the middle of a call
        cmd_q.push_back('{4'd0, 8'h66, 1'b1, 99, 8'h77});
        n = 0;
        do begin
            step();
            n++;
        end while (ch_req == '0 && n < 20);
        chk("mid_req_high", 32'(ch_req), 32'h1);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_async",
            32'({ch_req, ch_arg, cmd_ready, busy, rsp_valid}), 32'h0);
        chk("mid_rst_cnt", 32'(call_cnt), 32'h0);
        callee_q.delete();
        exp_q.delete();
        cmd_q.delete();
        req_active = 1'b0;
        rsp_hold = 1'b0;
        model_cnt = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("mid_ready_after", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_quiet", 32'({rsp_valid, busy, ch_req}), 32'h0);
        end

        // randomized run against the call model
        rdy_pct = 60;
        send_pct = 70;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0)
                c.ch = 4'($urandom_range(NUM_CH, 15));
            else
                c.ch = 4'($urandom_range(0, NUM_CH - 1));
            c.arg = 8'($urandom());
            c.has_out = 1'($urandom());
            c.res = 8'($urandom());
            if (r < 6)       c.d = $urandom_range(1, 5);
            else if (r == 6) c.d = TIMEOUT;
            else if (r == 7) c.d = TIMEOUT - 1;
            else if (r == 8) c.d = TIMEOUT + 1;
            else             c.d = $urandom_range(6, 12);
            cmd_q.push_back(c);
        end
        drain(30000);
        chk("final_call_cnt", 32'(call_cnt), 32'(model_cnt));
        chk("final_callee_left", callee_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
